// File: rtl/ks4_serial_add_seq_if.sv
// Operand/result handshake bundle for the nibble-serial adder sequencer.
// Ports: in_* (operand offer, valid/ready), out_* (result, valid/ready).
// Optional in_sub exists only when KS_SEQ_SUB_EN is defined.
// master = operand producer / result consumer, slave = sequencer.
interface ks4_serial_add_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef KS_SEQ_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

`ifdef KS_SEQ_SUB_EN
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
`endif
endinterface

// File: rtl/ks4_serial_add_seq.sv
// Nibble-serial W-bit adder sequencer driving an external 4-bit adder core.
// Ports: clk, rst_n (async, active low), ena (0 freezes state),
//   bus (operand/result handshake), busy, add_a/add_b/add_cin to the core,
//   add_sum/add_cout combinational return from the core.
// Optional: KS_SEQ_SUB_EN adds bus.in_sub for a - b (out_cout=1: no borrow).
module ks4_serial_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    ks4_serial_add_seq_if.slave        bus,
    output logic                       busy,
    output logic [3:0]                 add_a,
    output logic [3:0]                 add_b,
    output logic                       add_cin,
    input  logic [3:0]                 add_sum,
    input  logic                       add_cout
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          last;
    logic [W-1:0]  b_in;
    logic          cin_in;

    // Subtraction is a + ~b + 1; in_cin is ignored in that mode.
`ifdef KS_SEQ_SUB_EN
    assign b_in   = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign cin_in = bus.in_sub | bus.in_cin;
`else
    assign b_in   = bus.in_b;
    assign cin_in = bus.in_cin;
`endif

    assign last          = (idx_q == IW'(NIBBLES - 1));
    assign busy          = (state_q != S_IDLE);
    assign bus.in_ready  = ena && (state_q == S_IDLE);
    assign bus.out_valid = ena && (state_q == S_DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ena && bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = b_in;
                    carry_d = cin_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                add_a   = a_q[4*idx_q +: 4];
                add_b   = b_q[4*idx_q +: 4];
                add_cin = carry_q;
                if (ena) begin
                    sum_d[4*idx_q +: 4] = add_sum;
                    carry_d             = add_cout;
                    // idx holds on the final nibble so it never wraps.
                    if (last) begin
                        cout_d  = add_cout;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (ena && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_ks4_serial_add_seq.sv
// Self-checking bench for ks4_serial_add_seq (NIBBLES=4).
// Full-width arithmetic reference model plus directed literal cases.
module tb_ks4_serial_add_seq;
    localparam int NIB = 4;
    localparam int W   = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b0;
    logic       busy;
    logic [3:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout;
    logic       chk_en = 1'b0;
    logic       cur_sub;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ks4_serial_add_seq_if #(.NIBBLES(NIB)) bus ();

    ks4_serial_add_seq #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .bus      (bus),
        .busy     (busy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // External 4-bit adder core.
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

`ifdef KS_SEQ_SUB_EN
    assign cur_sub = bus.in_sub;
`else
    assign cur_sub = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: an operation in flight with adder cycles left,
    // a completed result waiting for drain, and the last result held.
    bit           m_pend = 1'b0;
    bit           m_done = 1'b0;
    int           m_left = 0;
    logic [W:0]   m_res  = '0;
    logic [W:0]   m_held = '0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;
    logic         m_cin  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_held <= '0;
        end else if (ena) begin
            if (!m_pend && !m_done) begin
                if (bus.in_valid) begin
                    m_a    <= bus.in_a;
                    m_b    <= cur_sub ? ~bus.in_b : bus.in_b;
                    m_cin  <= cur_sub | bus.in_cin;
                    m_res  <= {1'b0, bus.in_a}
                            + {1'b0, (cur_sub ? ~bus.in_b : bus.in_b)}
                            + (W+1)'(cur_sub | bus.in_cin);
                    m_pend <= 1'b1;
                    m_left <= NIB;
                end
            end else if (m_pend) begin
                if (m_left == 1) begin
                    m_pend <= 1'b0;
                    m_done <= 1'b1;
                    m_held <= m_res;
                end
                m_left <= m_left - 1;
            end else if (bus.out_ready) begin
                m_done <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int          k;
        logic [31:0] msk;
        logic [31:0] car;
        if (chk_en && rst_n) begin
            chk("in_ready", bus.in_ready, ena && !m_pend && !m_done);
            chk("out_valid", bus.out_valid, ena && m_done);
            chk("busy", busy, m_pend || m_done);
            if (!m_pend) begin
                chk("out_sum", bus.out_sum, m_held[W-1:0]);
                chk("out_cout", bus.out_cout, m_held[W]);
                chk("add_a_idle", add_a, 0);
                chk("add_b_idle", add_b, 0);
                chk("add_cin_idle", add_cin, 0);
            end else begin
                k   = NIB - m_left;
                msk = (32'd1 << (4*k)) - 32'd1;
                car = ((32'(m_a) & msk) + (32'(m_b) & msk)
                      + 32'(m_cin)) >> (4*k);
                chk("add_a", add_a, (32'(m_a) >> (4*k)) & 32'hF);
                chk("add_b", add_b, (32'(m_b) >> (4*k)) & 32'hF);
                chk("add_cin", add_cin, car[0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input int s0, input int sl, input int hold,
                          output int lat, output int cins,
                          output logic [W-1:0] sum, output logic cout);
        int g;
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_cin = cin;
`ifdef KS_SEQ_SUB_EN
        bus.in_sub = sub;
`endif
        bus.in_valid = 1'b1;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            step();
            g++;
        end
        if (g >= 50) chk("accept_timeout", 0, 1);
        step();
        bus.in_valid = 1'b0;
        lat  = 0;
        cins = 0;
        while (lat < 60) begin
            ena = !(lat >= s0 && lat < s0 + sl);
            #1;
            if (bus.out_valid) break;
            if (busy && ena) cins += int'(add_cin);
            step();
            lat++;
        end
        if (lat >= 60) chk("done_timeout", 0, 1);
        sum  = bus.out_sum;
        cout = bus.out_cout;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_sum", bus.out_sum, sum);
            chk("hold_cout", bus.out_cout, cout);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int           lat;
        int           cins;
        logic [W-1:0] s;
        logic         c;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
`ifdef KS_SEQ_SUB_EN
        bus.in_sub    = 1'b0;
`endif
        ena   = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sum", bus.out_sum, 0);
        chk("rst_out_cout", bus.out_cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_add_a", add_a, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step();

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 100, 0, 0, lat, cins, s, c);
        chk("add1_sum", s, 16'h5555);
        chk("add1_cout", c, 0);
        chk("add1_lat", lat, 4);

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 100, 0, 0, lat, cins, s, c);
        chk("ripple_sum", s, 16'h0000);
        chk("ripple_cout", c, 1);
        chk("ripple_cins", cins, 3);

        run_op(16'hABCD, 16'h1111, 1'b1, 1'b0, 100, 0, 10, lat, cins, s, c);
        chk("bp_sum", s, 16'hBCDF);
        chk("bp_cout", c, 0);

        bus.in_a     = 16'h1234;
        bus.in_b     = 16'h1111;
        bus.in_cin   = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_sum", bus.out_sum, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 100, 0, 0, lat, cins, s, c);
        chk("post_rst_sum", s, 16'h1010);
        chk("post_rst_cout", c, 0);

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 2, 3, 0, lat, cins, s, c);
        chk("stall_sum", s, 16'h0100);
        chk("stall_lat", lat, 7);
        ena = 1'b1;

`ifdef KS_SEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 100, 0, 0, lat, cins, s, c);
        chk("sub1_sum", s, 16'hFFFE);
        chk("sub1_cout", c, 0);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 100, 0, 0, lat, cins, s, c);
        chk("sub2_sum", s, 16'h0002);
        chk("sub2_cout", c, 1);
`endif

        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom % 2) == 0;
            bus.in_a      = W'($urandom);
            bus.in_b      = W'($urandom);
            bus.in_cin    = 1'($urandom);
            bus.out_ready = ($urandom % 3) != 0;
            ena           = ($urandom % 6) != 0;
`ifdef KS_SEQ_SUB_EN
            bus.in_sub    = 1'($urandom);
`endif
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        ena           = 1'b1;
        repeat (10) step();
        chk("final_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
